// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and the busy-handshake timeout,
// common to the transmit and receive paths.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } uart_state_e;

   localparam int BUSY_TIMEOUT = 4;
   localparam int TMR_W        = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with registered count/full/empty flags
// and a one-cycle overflow pulse for writes dropped while full.
module sync_fifo #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);

   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              wr_ok;
   logic              rd_ok;
   logic [ADDR_W:0]   count_nxt;

   assign wr_ok = wr_en & ~full & ~flush;
   assign rd_ok = rd_en & ~empty & ~flush;

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (wr_ok & ~rd_ok)
         count_nxt = count + (ADDR_W+1)'(1);
      else if (rd_ok & ~wr_ok)
         count_nxt = count - (ADDR_W+1)'(1);
   end

   // Flags are derived from the next count so they stay coherent with count every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_ok)
               wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_ok)
               rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         count    <= count_nxt;
         full     <= (count_nxt == DEPTH_C);
         empty    <= (count_nxt == '0);
         overflow <= wr_en & full;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter through a send-strobe / busy handshake.
//
// state        | meaning
// ST_IDLE      | wait for queued byte and idle transmitter; pop head into uart_tx_data
// ST_SEND      | byte latched; strobe is issued on the following cycle
// ST_WAIT_BUSY | wait for busy to rise, give up after BUSY_TIMEOUT cycles
// ST_WAIT_DONE | transmitter shifting; wait for busy to fall
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic [DATA_W-1:0] uart_tx_data,
   output logic              uart_tx_send,
   input  logic              uart_tx_busy
);

   uart_state_e       state;
   uart_state_e       state_nxt;
   logic [TMR_W-1:0]  tmr;
   logic              tmr_tc;
   logic              tmr_load;
   logic              pop;
   logic              send_nxt;
   logic [DATA_W-1:0] head;

   sync_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (head),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   assign tmr_tc = (tmr == TMR_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:
            if (!empty && !uart_tx_busy && !flush)
               state_nxt = ST_SEND;
         ST_SEND:
            state_nxt = ST_WAIT_BUSY;
         ST_WAIT_BUSY:
            if (uart_tx_busy)
               state_nxt = ST_WAIT_DONE;
            else if (tmr_tc)
               state_nxt = ST_IDLE;
         ST_WAIT_DONE:
            if (!uart_tx_busy)
               state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      pop      = (state == ST_IDLE) && (state_nxt == ST_SEND);
      send_nxt = (state == ST_SEND);
      tmr_load = (state == ST_SEND);
   end

   // Strobe is registered, so it lands one cycle after the byte is latched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uart_tx_data <= '0;
         uart_tx_send <= 1'b0;
         tmr          <= '0;
      end else begin
         uart_tx_send <= send_nxt;
         if (pop)
            uart_tx_data <= head;
         if (tmr_load)
            tmr <= TMR_W'(BUSY_TIMEOUT);
         else if ((state == ST_WAIT_BUSY) && (tmr != '0))
            tmr <= tmr - TMR_W'(1);
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: busy handshake model, strobe logging and hand-computed expectations.
module tb_uart_tx_fifo;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_en   = 1'b0;
   logic              flush   = 1'b0;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic [DATA_W-1:0] uart_tx_data;
   logic              uart_tx_send;
   logic              uart_tx_busy;

   logic busy_man      = 1'b0;
   logic busy_auto_sel = 1'b0;
   logic busy_mdl      = 1'b0;
   logic send_prev     = 1'b0;
   int   busy_len      = 100;
   int   busy_left     = 0;

   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;
   int   ovf_cnt = 0;
   int   last_wr_cyc = 0;
   logic [DATA_W-1:0] sdata[$];
   int                scyc[$];

   uart_tx_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_data      (wr_data),
      .wr_en        (wr_en),
      .flush        (flush),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .overflow     (overflow),
      .uart_tx_data (uart_tx_data),
      .uart_tx_send (uart_tx_send),
      .uart_tx_busy (uart_tx_busy)
   );

   assign uart_tx_busy = busy_auto_sel ? busy_mdl : busy_man;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Strobe/overflow logger plus transmitter model: busy rises the cycle after the strobe.
   always @(negedge clk) begin
      if (uart_tx_send) begin
         sdata.push_back(uart_tx_data);
         scyc.push_back(cyc);
      end
      if (overflow)
         ovf_cnt++;
      if (busy_left > 0)
         busy_left--;
      if (send_prev)
         busy_left = busy_len;
      busy_mdl  = (busy_left > 0);
      send_prev = uart_tx_send;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_byte(input logic [DATA_W-1:0] d);
      wr_data = d;
      wr_en   = 1'b1;
      @(posedge clk);
      #1;
      last_wr_cyc = cyc;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_strobes(input string tag, input int target, input int max_cyc);
      int n;
      n = 0;
      while (sdata.size() < target && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_strobes"}, sdata.size(), target);
   endtask

   initial begin
      int n0;
      int c0;
      int o0;
      int n;

      // Reset values
      repeat (3) @(negedge clk);
      check_eq("rst_count", count, 0);
      check_eq("rst_empty", empty, 1);
      check_eq("rst_full", full, 0);
      check_eq("rst_overflow", overflow, 0);
      check_eq("rst_send", uart_tx_send, 0);
      check_eq("rst_data", uart_tx_data, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte, busy for 100 cycles
      busy_auto_sel = 1'b1;
      busy_len      = 100;
      n0 = sdata.size();
      write_byte(8'h55);
      c0 = last_wr_cyc;
      wait_strobes("t1", n0 + 1, 20);
      check_eq("t1_data", sdata[n0], 8'h55);
      check_eq("t1_latency", scyc[n0], c0 + 2);
      repeat (10) @(negedge clk);
      check_eq("t1_data_held", uart_tx_data, 8'h55);
      check_eq("t1_count", count, 0);
      repeat (100) @(negedge clk);
      check_eq("t1_one_strobe", sdata.size(), n0 + 1);
      check_eq("t1_empty", empty, 1);

      // Fill 16 with busy held, then overflow
      busy_auto_sel = 1'b0;
      busy_man      = 1'b1;
      @(negedge clk);
      n0 = sdata.size();
      for (int i = 0; i < 16; i++) begin
         wr_data = 8'(i + 1);
         wr_en   = 1'b1;
         @(negedge clk);
      end
      wr_en = 1'b0;
      check_eq("t2_full", full, 1);
      check_eq("t2_count", count, 16);
      check_eq("t2_empty", empty, 0);
      o0 = ovf_cnt;
      write_byte(8'hAA);
      repeat (3) @(negedge clk);
      check_eq("t2_overflow_once", ovf_cnt - o0, 1);
      check_eq("t2_count_after_ovf", count, 16);
      check_eq("t2_no_send", sdata.size(), n0);

      // Drain in order with pointer wrap
      busy_len      = 3;
      busy_auto_sel = 1'b1;
      wait_strobes("t3", n0 + 16, 400);
      for (int i = 0; i < 16; i++)
         check_eq($sformatf("t3_order%0d", i), sdata[n0 + i], 8'(i + 1));
      repeat (30) @(negedge clk);
      check_eq("t3_no_aa", sdata.size(), n0 + 16);
      check_eq("t3_empty", empty, 1);
      check_eq("t3_count", count, 0);

      // Simultaneous write+pop at 5; write-while-full alongside a pop
      busy_auto_sel = 1'b0;
      busy_man      = 1'b1;
      @(negedge clk);
      n0 = sdata.size();
      for (int i = 0; i < 5; i++) begin
         wr_data = 8'(8'h21 + i);
         wr_en   = 1'b1;
         @(negedge clk);
      end
      check_eq("t4_count5", count, 5);
      busy_man = 1'b0;
      wr_data  = 8'h26;
      @(negedge clk);
      wr_en    = 1'b0;
      busy_man = 1'b1;
      check_eq("t4_count_stays5", count, 5);
      for (int i = 0; i < 11; i++) begin
         wr_data = 8'(8'h27 + i);
         wr_en   = 1'b1;
         @(negedge clk);
      end
      wr_en = 1'b0;
      check_eq("t4_full", full, 1);
      check_eq("t4_count16", count, 16);
      busy_man = 1'b0;
      @(negedge clk);
      o0      = ovf_cnt;
      wr_data = 8'hBB;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en         = 1'b0;
      busy_len      = 2;
      busy_auto_sel = 1'b1;
      check_eq("t4_count_pop_drop", count, 15);
      repeat (2) @(negedge clk);
      check_eq("t4_overflow", ovf_cnt - o0, 1);
      wait_strobes("t4", n0 + 17, 400);
      for (int i = 0; i < 17; i++)
         check_eq($sformatf("t4_order%0d", i), sdata[n0 + i], 8'(8'h21 + i));
      repeat (30) @(negedge clk);
      check_eq("t4_no_bb", sdata.size(), n0 + 17);
      check_eq("t4_empty", empty, 1);

      // Busy never rises: timeout then next byte
      busy_auto_sel = 1'b0;
      busy_man      = 1'b0;
      n0 = sdata.size();
      write_byte(8'h41);
      c0 = last_wr_cyc;
      write_byte(8'h42);
      wait_strobes("t5", n0 + 2, 40);
      check_eq("t5_first_lat", scyc[n0], c0 + 2);
      check_eq("t5_second_lat", scyc[n0 + 1], c0 + 8);
      check_eq("t5_second_data", sdata[n0 + 1], 8'h42);
      repeat (10) @(negedge clk);

      // Flush during WAIT_DONE with 3 queued
      n0 = sdata.size();
      write_byte(8'h61);
      n = 0;
      while (!uart_tx_send && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("t6_strobe", uart_tx_send, 1);
      busy_man = 1'b1;
      write_byte(8'h62);
      write_byte(8'h63);
      write_byte(8'h64);
      check_eq("t6_count3", count, 3);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_eq("t6_flush_count", count, 0);
      check_eq("t6_flush_empty", empty, 1);
      check_eq("t6_data_kept", uart_tx_data, 8'h61);
      busy_man = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("t6_no_more", sdata.size(), n0 + 1);

      // Asynchronous reset mid-transfer
      write_byte(8'h77);
      write_byte(8'h78);
      write_byte(8'h79);
      n = 0;
      while (!uart_tx_send && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("t7_strobe", uart_tx_send, 1);
      check_eq("t7_count2", count, 2);
      rst_n = 1'b0;
      #1;
      check_eq("t7_send", uart_tx_send, 0);
      check_eq("t7_data", uart_tx_data, 0);
      check_eq("t7_count", count, 0);
      check_eq("t7_empty", empty, 1);
      check_eq("t7_full", full, 0);
      check_eq("t7_overflow", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n0 = sdata.size();
      repeat (20) @(negedge clk);
      check_eq("t7_no_send_after_rst", sdata.size(), n0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set FIFO depth to 2**ADDR_W entries.
REQ-002 Parameter DATA_W, default 8, SHALL set byte width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 wr_data  input  DATA_W  SHALL be the byte to enqueue.
REQ-006 wr_en  input  1  SHALL be the enqueue strobe, one byte per high cycle.
REQ-007 flush  input  1  SHALL be the synchronous discard of all queued bytes.
REQ-008 full  output  1  SHALL flag count == 2**ADDR_W.
REQ-009 empty  output  1  SHALL flag count == 0.
REQ-010 count  output  ADDR_W+1  SHALL give the number of queued bytes.
REQ-011 overflow  output  1  SHALL pulse for one cycle when a write is dropped.
REQ-012 uart_tx_data  output  DATA_W  SHALL be the byte presented to the downstream transmitter.
REQ-013 uart_tx_send  output  1  SHALL be the one-cycle send strobe to the transmitter.
REQ-014 uart_tx_busy  input  1  SHALL be the transmitter busy flag; it rises the cycle after the strobe and falls after the stop bit.

Function
REQ-015 Writes SHALL be accepted when wr_en=1 and full=0 at the clock edge; wr_en=1 with full=1 SHALL drop the byte and assert overflow on the next cycle, even if a pop occurs in the same cycle.
REQ-016 Storage SHALL be a circular buffer; read and write pointers SHALL be ADDR_W bits wide and wrap modulo depth with no special case.
REQ-017 count SHALL be incremented on accept-only, decremented on pop-only, and left unchanged on simultaneous accept and pop.
REQ-018 The FSM SHALL have four states:
- IDLE
- SEND
- WAIT_BUSY
- WAIT_DONE
REQ-019 IDLE: when empty=0 and uart_tx_busy=0, the FSM SHALL load uart_tx_data from the head entry, pop it, and go to SEND.
REQ-020 SEND: uart_tx_send SHALL be 1 for exactly this one cycle; the FSM SHALL then go to WAIT_BUSY.
REQ-021 WAIT_BUSY: when uart_tx_busy=1 the FSM SHALL go to WAIT_DONE; if busy stays 0 for 4 cycles, it SHALL return to IDLE (the byte is lost; no retry).
REQ-022 WAIT_DONE: when uart_tx_busy=0 the FSM SHALL return to IDLE.
REQ-023 uart_tx_data SHALL be registered and held stable from SEND until the FSM re-enters IDLE.
REQ-024 Latency: a byte written into an empty FIFO with the FSM in IDLE at edge N SHALL produce uart_tx_send=1 in the cycle following edge N+2.
REQ-025 Back-to-back: the next byte's strobe SHALL follow no earlier than 2 cycles after uart_tx_busy falls.
REQ-026 flush SHALL have priority over wr_en and pop: pointers and count SHALL go to 0 next cycle; an in-flight byte (SEND/WAIT_*) SHALL complete normally.
REQ-027 full, empty and count SHALL be registered and consistent with each other in every cycle.

Reset
REQ-028 On rst_n=0, pointers, count, overflow, uart_tx_send and uart_tx_data SHALL be 0; empty=1; full=0; FSM=IDLE.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer immediately; storage contents need not be reset.
REQ-030 The first strobe after reset release SHALL require a fresh write.

Structure
REQ-031 FSM state encodings (2 bits) and the WAIT_BUSY timeout constant (4) SHALL live in a shared uart defines include, also used by the receive path.
REQ-032 The storage, pointers and count SHALL be a sub-module sync_fifo (ADDR_W, DATA_W), reusable for an RX FIFO; the FSM SHALL stay in uart_tx_fifo.

Verification
REQ-033 Write 0x55 into an empty FIFO, with busy modelled as high 1 cycle after strobe for 100 cycles -> one strobe with uart_tx_data=0x55 at the REQ-024 latency, and count returns to 0.
REQ-034 Write 0x01..0x10 in 16 consecutive cycles while busy is held high -> full=1 and count=16; a 17th write 0xAA -> overflow pulses once and 0xAA is never sent.
REQ-035 Fill, release busy, drain all 16 bytes -> bytes emerge in order 0x01..0x10; pointers wrap; empty=1 at end.
REQ-036 Simultaneous write and pop at count=5 -> count stays 5; write while full in the same cycle as a pop -> dropped and overflow=1.
REQ-037 Busy never rises after a strobe -> FSM returns to IDLE after 4 cycles, then sends the next byte.
REQ-038 flush during WAIT_DONE with 3 bytes queued -> the current byte completes, count=0, no further strobes; rst_n low mid-transfer -> all outputs at REQ-028 values asynchronously.
